switch_encoder: RTL

Debounced 8-to-3 priority encoder with a valid/ready output. It is the counterpart of the board-level 3-to-8 `decoder`: the decoder expands a 3-bit code onto one-hot LEDs, and this block turns presses on up to eight switch/key lines back into a 3-bit code. On the DE1-SoC top it sits between `SW[7:0]` and any code consumer, such as the decoder, a HEX display or the CPU input port. It synchronises and debounces the raw lines and detects new presses. Each new press is emitted as one registered code word held until the consumer accepts it.

---
 rtl/switch_encoder.sv | 108 ++++++++++
 1 files changed

// File: rtl/switch_encoder.sv
// Debounced 8-to-3 priority encoder for switch/key lines.
// Each new press becomes one held code word with a valid/ready handshake.
module switch_encoder #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       ready,
  output logic [2:0] code,
  output logic       valid,
  output logic       multi,
  output logic       overflow,
  output logic       any
);

  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE);

  logic [7:0]      s1_q, s2_q, s2_prev_q, stable_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            update, evt;
  logic [7:0]      rise;
  logic [2:0]      rise_code;
  logic            rise_multi;

  logic [2:0]      code_q, code_d;
  logic            multi_q, multi_d;
  logic            valid_q, valid_d;
  logic            overflow_q, overflow_d;
  logic            any_q, any_d;

  // Stability counter: restarts on any change at the synchroniser output.
  always_comb begin
    cnt_d = cnt_q;
    if (s2_q != s2_prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign update = (cnt_q == CntMax) && (s2_q == s2_prev_q) && (s2_q != stable_q);
  assign rise   = s2_q & ~stable_q;
  assign evt    = update && (rise != 8'd0);

  always_comb begin
    rise_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (rise[i]) rise_code = 3'(i);
    end
    // Clearing the lowest set bit leaves a residue only when two or more bits are set.
    rise_multi = |(rise & (rise - 8'd1));
  end

  // Holding register: accept first, then load into the freed slot or drop.
  always_comb begin
    code_d     = code_q;
    multi_d    = multi_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (evt) begin
      if (!valid_d) begin
        code_d  = rise_code;
        multi_d = rise_multi;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  assign any_d = update ? |s2_q : any_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s2_prev_q  <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      code_q     <= '0;
      multi_q    <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      any_q      <= 1'b0;
    end else begin
      s1_q       <= in;
      s2_q       <= s1_q;
      s2_prev_q  <= s2_q;
      cnt_q      <= cnt_d;
      if (update) stable_q <= s2_q;
      code_q     <= code_d;
      multi_q    <= multi_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      any_q      <= any_d;
    end
  end

  assign code     = code_q;
  assign multi    = multi_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign any      = any_q;

endmodule
